rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..32).
REQ-002 The block SHALL have parameter MAX_HOLD, default 4, maximum consecutive grant cycles while other requests are pending; 0 = unlimited.
REQ-003 The block SHALL have parameter IDX_W, default $clog2(N_REQ), width of gnt_idx.
REQ-004 The block SHALL have port clock  in  1  rising-edge clock.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port req  in  N_REQ  request vector; bit i = requester i.
REQ-007 The block SHALL have port prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-008 The block SHALL have port gnt  out  N_REQ  registered grant, one-hot or zero.
REQ-009 The block SHALL have port gnt_valid  out  1  high when gnt is non-zero.
REQ-010 The block SHALL have port gnt_idx  out  IDX_W  index of the current owner; 0 when gnt_valid=0.
REQ-011 The block SHALL have port hold_expired  out  1  one-cycle pulse marking a forced re-arbitration.

Function
REQ-012 The block SHALL use two states: IDLE (no owner) and GRANT (one owner).
REQ-013 All outputs SHALL be registered; gnt SHALL appear on the edge that samples the winning req, giving 1-cycle latency.
REQ-014 In IDLE with req=0, the block SHALL stay in IDLE with gnt=0.
REQ-015 In IDLE with req!=0, the block SHALL grant the winner and go to GRANT with hold_cnt=1.
REQ-016 In GRANT with req[owner]=1 and (MAX_HOLD=0, or hold_cnt<MAX_HOLD, or no other req bit set), the block SHALL keep the owner and increment hold_cnt, saturating at MAX_HOLD.
REQ-017 In GRANT with req[owner]=0 and another req set, the block SHALL grant the new winner on the same edge, with no idle cycle, and hold_cnt=1.
REQ-018 In GRANT with req[owner]=0 and no other req, the block SHALL go to IDLE and clear gnt.
REQ-019 In GRANT with req[owner]=1, hold_cnt=MAX_HOLD (MAX_HOLD>0) and another req set, the block SHALL exclude the owner from the search, grant the winner, set hold_cnt=1 and pulse hold_expired on that edge.
REQ-020 When a single requester holds continuously past MAX_HOLD, it SHALL keep the grant, hold_cnt SHALL reload to 1, and hold_expired SHALL stay low.
REQ-021 In round-robin mode, the search SHALL start at (last_owner+1) mod N_REQ and wrap around; last_owner SHALL update on every new grant.
REQ-022 In fixed mode, the winner SHALL be the lowest set index among eligible requesters; last_owner SHALL still update.
REQ-023 A prio_mode change SHALL take effect only at the next arbitration decision and SHALL NOT revoke a current grant.
REQ-024 gnt SHALL never have more than one bit set.
REQ-025 gnt_valid SHALL equal |gnt, and gnt_idx SHALL equal the encoded gnt.
REQ-026 hold_cnt width SHALL be $clog2(MAX_HOLD+1) (minimum 1 bit).

Reset
REQ-027 Asserting reset SHALL immediately force gnt=0, gnt_valid=0, gnt_idx=0, hold_expired=0, state=IDLE and hold_cnt=0, independent of clock.
REQ-028 Reset SHALL set last_owner=N_REQ-1 so that index 0 has top round-robin priority on the first decision.
REQ-029 Reset asserted mid-grant SHALL drop the grant without completing the hold; the first edge after deassertion SHALL arbitrate as from IDLE.

Verification (N_REQ=4, MAX_HOLD=4)
REQ-030 First request after reset, RR, req=1010 -> next edge gnt=0010, gnt_idx=1, gnt_valid=1.
REQ-031 RR, req=1111 held continuously -> gnt is 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001; hold_expired pulses at each switch.
REQ-032 Release handoff: owner 0 drops req after 2 grant cycles while req[2]=1 -> next edge gnt=0100, no zero cycle, hold_expired=0.
REQ-033 Fixed mode, req=1110, owner 1 at expiry -> gnt=0100; at owner 2 expiry -> gnt=0010.
REQ-034 Single requester, req=0100 for 12 cycles -> gnt stays 0100, hold_expired stays 0; then req=0 -> next edge gnt=0000, state IDLE.
REQ-035 Reset mid-grant: gnt=0010, reset asserted between edges -> gnt=0000 and gnt_idx=0 before the next edge; after release with req=1111 -> gnt=0001.

Source files
------------

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with a bounded hold time.
// An owner keeps the grant while it requests. Once it has held for MAX_HOLD
// cycles and someone else is waiting, it is forced off and hold_expired pulses.
// All outputs are registered, so a grant appears one edge after its request.
module rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDX_W    = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             prio_mode,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             hold_expired
);

  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_nxt;
  logic [IDX_W-1:0] last_owner, last_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             exp_nxt;

  logic [N_REQ-1:0] elig;
  logic [IDX_W-1:0] win, cand;
  logic             win_found;
  logic             own_req, others, at_limit, take;

  // The owner is the only set bit of gnt, so masking req with gnt isolates it.
  assign own_req  = |(req & gnt);
  assign others   = |(req & ~gnt);
  assign at_limit = (MAX_HOLD > 0) && (hold_cnt == HC_W'(MAX_HOLD));

  // In GRANT the search only ever needs to consider non-owners: the owner is
  // either gone or being forced off.
  assign elig = (state == GRANT) ? (req & ~gnt) : req;

  // Winner search: lowest index in fixed mode, otherwise start after last_owner.
  always_comb begin
    win       = '0;
    cand      = '0;
    win_found = 1'b0;
    if (prio_mode) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && elig[i]) begin
          win       = IDX_W'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IDX_W'((int'(last_owner) + k) % N_REQ);
        if (!win_found && elig[cand]) begin
          win       = cand;
          win_found = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last_owner;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    exp_nxt   = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) take = 1'b1;
      end
      GRANT: begin
        if (own_req && !(at_limit && others)) begin
          // Keep the owner; a lone requester at the limit restarts its count.
          if (MAX_HOLD == 0)  hold_nxt = HC_W'(1);
          else if (at_limit)  hold_nxt = HC_W'(1);
          else                hold_nxt = hold_cnt + 1'b1;
        end else if (own_req) begin
          take    = 1'b1;
          exp_nxt = 1'b1;
        end else if (others) begin
          take = 1'b1;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          idx_nxt   = '0;
          hold_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      state_nxt    = GRANT;
      gnt_nxt      = '0;
      gnt_nxt[win] = 1'b1;
      idx_nxt      = win;
      last_nxt     = win;
      hold_nxt     = HC_W'(1);
    end
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      last_owner   <= IDX_W'(N_REQ - 1);
      gnt          <= '0;
      gnt_valid    <= 1'b0;
      gnt_idx      <= '0;
      hold_expired <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      last_owner   <= last_nxt;
      gnt          <= gnt_nxt;
      gnt_valid    <= |gnt_nxt;
      gnt_idx      <= idx_nxt;
      hold_expired <= exp_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (N_REQ=4, MAX_HOLD=4): directed vector table,
// hand-written corner sequences, and randomized traffic against a model.
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req   = '0;
  logic         prio_mode = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;
  logic         hold_expired;

  rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clock(clock), .reset(reset), .req(req), .prio_mode(prio_mode),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .hold_expired(hold_expired)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic int enc(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic chk_out(input string name, input logic [N-1:0] eg, input logic ee);
    chk({name, ".gnt"},       int'(gnt),          int'(eg));
    chk({name, ".valid"},     int'(gnt_valid),    int'(|eg));
    chk({name, ".idx"},       int'(gnt_idx),      enc(eg));
    chk({name, ".expired"},   int'(hold_expired), int'(ee));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    #2;
    chk_out("reset", 4'b0000, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: owner/last as plain integers, rules applied directly.
  int m_owner, m_last, m_hold;

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_hold  = 0;
  endtask

  function automatic int pick(input logic [N-1:0] cands, input logic p);
    if (p) begin
      for (int i = 0; i < N; i++) if (cands[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (cands[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic p,
                            output logic [N-1:0] eg, output logic ee);
    logic [N-1:0] oth;
    int w;
    ee = 1'b0;
    if (m_owner < 0) begin
      if (r != 0) begin
        w = pick(r, p); m_owner = w; m_last = w; m_hold = 1;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (r[m_owner] && (m_hold < MH || oth == 0)) begin
        m_hold = (m_hold < MH) ? m_hold + 1 : 1;
      end else if (oth != 0) begin
        ee = r[m_owner];
        w = pick(oth, p); m_owner = w; m_last = w; m_hold = 1;
      end else begin
        m_owner = -1;
      end
    end
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         prio;
    logic [N-1:0] gnt;
    logic         exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [N-1:0] r, input logic p, input logic [N-1:0] g, input logic e);
    vec_t v;
    v.req = r; v.prio = p; v.gnt = g; v.exp = e;
    vecs.push_back(v);
  endtask

  logic [N-1:0] eg;
  logic         ee;

  initial begin
    // Directed table, applied one cycle per entry straight after reset.
    add(4'b1010, 0, 4'b0010, 0);  // first request: index 1 wins
    add(4'b0000, 0, 4'b0000, 0);  // owner drops, nobody else: idle
    add(4'b0101, 0, 4'b0100, 0);  // RR resumes after 1: index 2
    add(4'b0101, 0, 4'b0100, 0);
    add(4'b0001, 0, 4'b0001, 0);  // release handoff, no gap
    add(4'b0011, 0, 4'b0001, 0);
    add(4'b0011, 0, 4'b0001, 0);
    add(4'b0011, 0, 4'b0001, 0);
    add(4'b0011, 0, 4'b0010, 1);  // hold limit reached, forced switch
    add(4'b0011, 1, 4'b0010, 0);  // mode change does not revoke
    add(4'b0011, 1, 4'b0010, 0);
    add(4'b0011, 1, 4'b0010, 0);
    add(4'b0011, 1, 4'b0001, 1);
    add(4'b1111, 1, 4'b0001, 0);
    add(4'b1111, 1, 4'b0001, 0);
    add(4'b1111, 1, 4'b0001, 0);
    add(4'b1111, 1, 4'b0010, 1);  // fixed: lowest excluding owner 0
    for (int i = 0; i < 3; i++) add(4'b1110, 1, 4'b0010, 0);
    add(4'b1110, 1, 4'b0100, 1);  // owner 1 expires -> 2
    for (int i = 0; i < 3; i++) add(4'b1110, 1, 4'b0100, 0);
    add(4'b1110, 1, 4'b0010, 1);  // owner 2 expires -> 1
    add(4'b0000, 1, 4'b0000, 0);

    #1;
    do_reset();
    foreach (vecs[i]) begin
      req = vecs[i].req;
      prio_mode = vecs[i].prio;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].exp);
    end
    prio_mode = 1'b0;

    // Full RR rotation under constant contention.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      req = 4'b1111;
      tick();
      chk_out($sformatf("rot%0d", c), 4'(1 << ((c / 4) % 4)), (c > 0) && (c % 4 == 0));
    end

    // Release handoff after two grant cycles.
    do_reset();
    req = 4'b0101; tick(); chk_out("hand0", 4'b0001, 0);
    tick();                 chk_out("hand1", 4'b0001, 0);
    req = 4'b0100; tick(); chk_out("hand2", 4'b0100, 0);

    // Lone requester holds past the limit without expiring.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req = 4'b0100; tick();
      chk_out($sformatf("solo%0d", c), 4'b0100, 0);
    end
    req = 4'b0000; tick(); chk_out("solo_end", 4'b0000, 0);

    // Reset between edges drops the grant at once.
    do_reset();
    req = 4'b0010; tick(); chk_out("mid_gnt", 4'b0010, 0);
    #2 reset = 1'b1;
    #1 chk_out("mid_rst", 4'b0000, 0);
    req = 4'b1111;
    @(posedge clock);
    #1 reset = 1'b0;
    tick(); chk_out("mid_after", 4'b0001, 0);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        model_reset();
        continue;
      end
      if ($urandom_range(0, 19) == 0) prio_mode = ~prio_mode;
      case ($urandom_range(0, 2))
        0:       req = 4'($urandom_range(0, 15));
        1:       req = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        default: req = req;
      endcase
      tick();
      model_step(req, prio_mode, eg, ee);
      chk_out($sformatf("rand%0d", c), eg, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
